mess_credit_engine: RTL and testbench

- Sequential, multi-account successor to the single-shot credit ALU.
- Holds a balance register per student account and accepts one debit or recharge transaction at a time over a valid/ready request port.
- Applies the fixed meal costs, with insufficient-credit rejection and saturating recharge.
- Returns the new balance in binary and, via a multi-cycle double-dabble converter, as packed BCD ready for the 7-segment decoders.

---
 rtl/mess_credit_engine_pkg.sv | 20 ++
 rtl/bcd_convert_seq.sv | 91 +++++++++
 rtl/mess_credit_engine.sv | 213 +++++++++++++++++++++
 tb/tb_mess_credit_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mess_credit_engine_pkg.sv
// mess_pkg: shared definitions for the mess credit engine.
//   - request op field bit positions
//   - transaction FSM state encoding
//   - default meal costs
package mess_pkg;

    localparam int OP_RECHARGE_BIT = 0;   // 1 = recharge, 0 = debit
    localparam int OP_COSTSEL_BIT  = 1;   // 1 = cost B, 0 = cost A

    localparam int DEF_COST_A = 49;
    localparam int DEF_COST_B = 50;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CONV = 2'd2,
        RESP = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: sequential double-dabble binary-to-BCD converter.
//   clk, rst_n : clock, async active-low reset
//   start      : load bin and begin conversion (one BAL_W-cycle run)
//   bin        : binary value sampled on the start cycle
//   done       : one-cycle pulse, high the cycle after the last shift
//   bcd        : packed BCD result, most significant digit in the top nibble
module bcd_convert_seq #(
    parameter int BAL_W      = 8,
    parameter int BCD_DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BAL_W-1:0]          bin,
    output logic                      done,
    output logic [4*BCD_DIGITS-1:0]   bcd
);

    localparam int SR_W  = 4*BCD_DIGITS + BAL_W;
    localparam int CNT_W = $clog2(BAL_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BAL_W - 1);

    logic [SR_W-1:0]         sr_q, sr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d;
    logic [SR_W-1:0]         sr_adj_s;

    // Add 3 to every BCD digit that is 5 or more, ahead of the left shift.
    function automatic logic [SR_W-1:0] dd_adjust(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] r;
        r = sr;
        for (int d = 0; d < BCD_DIGITS; d++) begin
            if (r[BAL_W+4*d +: 4] >= 4'd5) begin
                r[BAL_W+4*d +: 4] = r[BAL_W+4*d +: 4] + 4'd3;
            end else begin
                r[BAL_W+4*d +: 4] = r[BAL_W+4*d +: 4];
            end
        end
        return r;
    endfunction

    // Next-state logic for the shift register, step counter and result.
    always_comb begin
        sr_adj_s = dd_adjust(sr_q);
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        bcd_d    = bcd_q;
        done_d   = 1'b0;
        if (start) begin
            sr_d   = {{(4*BCD_DIGITS){1'b0}}, bin};
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            sr_d = {sr_adj_s[SR_W-2:0], 1'b0};
            if (cnt_q == LAST_CNT) begin
                busy_d = 1'b0;
                cnt_d  = '0;
                bcd_d  = sr_adj_s[SR_W-2 -: 4*BCD_DIGITS];
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            busy_d = 1'b0;
        end
    end

    // Converter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            bcd_q  <= '0;
        end else begin
            sr_q   <= sr_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
            bcd_q  <= bcd_d;
        end
    end

    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: rtl/mess_credit_engine.sv
// mess_credit_engine: multi-account meal credit engine.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/req_ready   : request handshake (accepted only in IDLE)
//   req_acct, req_op      : target account; op bit0 recharge, bit1 cost select
//   rsp_valid/rsp_ready   : response handshake
//   rsp_ok/err/sat        : applied / bad account / recharge clipped
//   rsp_balance, rsp_bcd  : resulting balance in binary and packed BCD
module mess_credit_engine
    import mess_pkg::*;
#(
    parameter int BAL_W      = 8,
    parameter int NUM_ACCTS  = 4,
    parameter int ACCT_W     = 2,
    parameter int COST_A     = DEF_COST_A,
    parameter int COST_B     = DEF_COST_B,
    parameter int INIT_BAL   = 100,
    parameter int MAX_BAL    = 2**BAL_W - 1,
    parameter int BCD_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ACCT_W-1:0]       req_acct,
    input  logic [1:0]              req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_ok,
    output logic                    rsp_err,
    output logic                    rsp_sat,
    output logic [BAL_W-1:0]        rsp_balance,
    output logic [4*BCD_DIGITS-1:0] rsp_bcd
);

    localparam logic [BAL_W-1:0]  COST_A_V = BAL_W'(COST_A);
    localparam logic [BAL_W-1:0]  COST_B_V = BAL_W'(COST_B);
    localparam logic [BAL_W-1:0]  INIT_V   = BAL_W'(INIT_BAL);
    localparam logic [BAL_W-1:0]  MAX_B    = BAL_W'(MAX_BAL);
    localparam logic [BAL_W:0]    MAX_W    = (BAL_W+1)'(MAX_BAL);
    localparam logic [ACCT_W:0]   NUM_V    = (ACCT_W+1)'(NUM_ACCTS);

    state_e                  state_q, state_d;
    logic [ACCT_W-1:0]       acct_q, acct_d;
    logic [1:0]              op_q, op_d;
    logic [BAL_W-1:0]        bal_q [NUM_ACCTS];
    logic [BAL_W-1:0]        bal_d [NUM_ACCTS];
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_ok_q, rsp_ok_d;
    logic                    rsp_err_q, rsp_err_d;
    logic                    rsp_sat_q, rsp_sat_d;
    logic [BAL_W-1:0]        rsp_balance_q, rsp_balance_d;
    logic [4*BCD_DIGITS-1:0] rsp_bcd_q, rsp_bcd_d;

    logic                    acct_bad_s;
    logic [BAL_W-1:0]        cur_bal_s;
    logic [BAL_W-1:0]        cost_s;
    logic [BAL_W:0]          sum_s;
    logic [BAL_W-1:0]        res_bal_s;
    logic                    res_ok_s;
    logic                    res_sat_s;
    logic                    wr_en_s;
    logic                    conv_start_s;
    logic                    conv_done_s;
    logic [4*BCD_DIGITS-1:0] conv_bcd_s;

    // Transaction datapath: evaluates the latched request against its account.
    always_comb begin
        cur_bal_s = '0;
        for (int i = 0; i < NUM_ACCTS; i++) begin
            if (acct_q == ACCT_W'(i)) begin
                cur_bal_s = bal_q[i];
            end else begin
                cur_bal_s = cur_bal_s;
            end
        end
        acct_bad_s = ({1'b0, acct_q} >= NUM_V);
        cost_s     = op_q[OP_COSTSEL_BIT] ? COST_B_V : COST_A_V;
        sum_s      = {1'b0, cur_bal_s} + {1'b0, cost_s};
        res_bal_s  = '0;
        res_ok_s   = 1'b0;
        res_sat_s  = 1'b0;
        if (acct_bad_s) begin
            res_bal_s = '0;
        end else if (op_q[OP_RECHARGE_BIT]) begin
            res_ok_s = 1'b1;
            if (sum_s > MAX_W) begin
                res_bal_s = MAX_B;
                res_sat_s = 1'b1;
            end else begin
                res_bal_s = sum_s[BAL_W-1:0];
            end
        end else if (cur_bal_s >= cost_s) begin
            res_bal_s = cur_bal_s - cost_s;
            res_ok_s  = 1'b1;
        end else begin
            res_bal_s = cur_bal_s;   // rejected debit reports the untouched balance
        end
        // Only real changes reach the account file.
        wr_en_s = res_ok_s && (res_bal_s != cur_bal_s);
    end

    // FSM next-state, account write-back and response field updates.
    always_comb begin
        state_d       = state_q;
        acct_d        = acct_q;
        op_d          = op_q;
        bal_d         = bal_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_ok_d      = rsp_ok_q;
        rsp_err_d     = rsp_err_q;
        rsp_sat_d     = rsp_sat_q;
        rsp_balance_d = rsp_balance_q;
        rsp_bcd_d     = rsp_bcd_q;
        conv_start_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    acct_d  = req_acct;
                    op_d    = req_op;
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                rsp_ok_d      = res_ok_s;
                rsp_err_d     = acct_bad_s;
                rsp_sat_d     = res_sat_s;
                rsp_balance_d = res_bal_s;
                conv_start_s  = 1'b1;
                for (int i = 0; i < NUM_ACCTS; i++) begin
                    if (wr_en_s && (acct_q == ACCT_W'(i))) begin
                        bal_d[i] = res_bal_s;
                    end else begin
                        bal_d[i] = bal_q[i];
                    end
                end
                state_d = CONV;
            end
            CONV: begin
                if (conv_done_s) begin
                    rsp_bcd_d   = conv_bcd_s;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    state_d = CONV;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    // State, request latch, account file and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            acct_q        <= '0;
            op_q          <= 2'b00;
            for (int i = 0; i < NUM_ACCTS; i++) begin
                bal_q[i] <= INIT_V;
            end
            rsp_valid_q   <= 1'b0;
            rsp_ok_q      <= 1'b0;
            rsp_err_q     <= 1'b0;
            rsp_sat_q     <= 1'b0;
            rsp_balance_q <= '0;
            rsp_bcd_q     <= '0;
        end else begin
            state_q       <= state_d;
            acct_q        <= acct_d;
            op_q          <= op_d;
            bal_q         <= bal_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_ok_q      <= rsp_ok_d;
            rsp_err_q     <= rsp_err_d;
            rsp_sat_q     <= rsp_sat_d;
            rsp_balance_q <= rsp_balance_d;
            rsp_bcd_q     <= rsp_bcd_d;
        end
    end

    bcd_convert_seq #(
        .BAL_W      (BAL_W),
        .BCD_DIGITS (BCD_DIGITS)
    ) u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start_s),
        .bin   (res_bal_s),
        .done  (conv_done_s),
        .bcd   (conv_bcd_s)
    );

    assign req_ready   = (state_q == IDLE);
    assign rsp_valid   = rsp_valid_q;
    assign rsp_ok      = rsp_ok_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_sat     = rsp_sat_q;
    assign rsp_balance = rsp_balance_q;
    assign rsp_bcd     = rsp_bcd_q;

endmodule

// File: tb/tb_mess_credit_engine.sv
// Scoreboard bench for mess_credit_engine (three accounts, index 3 invalid).
module tb_mess_credit_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_acct;
    logic [1:0]  req_op;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_ok;
    logic        rsp_err;
    logic        rsp_sat;
    logic [7:0]  rsp_balance;
    logic [11:0] rsp_bcd;

    typedef struct packed {
        logic        ok;
        logic        err;
        logic        sat;
        logic [7:0]  bal;
        logic [11:0] bcd;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    // Balance walk on account 2 ending exactly at 255 without saturation.
    logic [1:0] t_op  [13] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b00,
                               2'b11, 2'b00, 2'b11, 2'b00, 2'b11, 2'b11};
    int         t_bal [13] = '{150, 200, 151, 201, 152, 202, 153,
                               203, 154, 204, 155, 205, 255};

    mess_credit_engine #(
        .BAL_W      (8),
        .NUM_ACCTS  (3),
        .ACCT_W     (2),
        .COST_A     (49),
        .COST_B     (50),
        .INIT_BAL   (100),
        .MAX_BAL    (255),
        .BCD_DIGITS (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_acct    (req_acct),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_ok      (rsp_ok),
        .rsp_err     (rsp_err),
        .rsp_sat     (rsp_sat),
        .rsp_balance (rsp_balance),
        .rsp_bcd     (rsp_bcd)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] bcd_of(input int v);
        logic [3:0] h, t, u;
        h = 4'((v / 100) % 10);
        t = 4'((v / 10) % 10);
        u = 4'(v % 10);
        return {h, t, u};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_rsp(input logic ok, input logic err, input logic sat, input int bal);
        exp_t e;
        e.ok  = ok;
        e.err = err;
        e.sat = sat;
        e.bal = 8'(bal);
        e.bcd = bcd_of(bal);
        sb_q.push_back(e);
    endtask

    // Present a request and return just after the edge that accepts it.
    task automatic send(input logic [1:0] acct, input logic [1:0] op);
        int n;
        req_valid = 1'b1;
        req_acct  = acct;
        req_op    = op;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req_ready && n < 40);
        if (!req_ready) begin
            check("req_ready_timeout", 32'(req_ready), 32'd1);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    // Wait for rsp_valid after an accept edge and check the 10-cycle latency.
    task automatic wait_rsp(input string name);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!rsp_valid && cyc < 40);
        check(name, 32'(cyc - 1), 32'd10);
    endtask

    task automatic txn(input logic [1:0] acct, input logic [1:0] op,
                       input logic ok, input logic err, input logic sat, input int bal);
        expect_rsp(ok, err, sat, bal);
        send(acct, op);
        wait_rsp("latency");
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare each handshaken response against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                exp_t g;
                e = sb_q.pop_front();
                g = {rsp_ok, rsp_err, rsp_sat, rsp_balance, rsp_bcd};
                check("rsp {ok,err,sat,bal,bcd}", 32'(g), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [22:0] snap;
        logic        stable;
        logic        rdy_seen;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_acct  = 2'b00;
        req_op    = 2'b00;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset req_ready",   32'(req_ready),   32'd1);
        check("reset rsp_valid",   32'(rsp_valid),   32'd0);
        check("reset rsp_ok",      32'(rsp_ok),      32'd0);
        check("reset rsp_err",     32'(rsp_err),     32'd0);
        check("reset rsp_sat",     32'(rsp_sat),     32'd0);
        check("reset rsp_balance", 32'(rsp_balance), 32'd0);
        check("reset rsp_bcd",     32'(rsp_bcd),     32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Account 0: debits and insufficient-credit rejects.
        txn(2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 51);
        txn(2'd0, 2'b10, 1'b1, 1'b0, 1'b0, 1);
        txn(2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1);
        txn(2'd0, 2'b10, 1'b0, 1'b0, 1'b0, 1);

        // Account 1: saturating recharge.
        txn(2'd1, 2'b11, 1'b1, 1'b0, 1'b0, 150);
        txn(2'd1, 2'b11, 1'b1, 1'b0, 1'b0, 200);
        txn(2'd1, 2'b11, 1'b1, 1'b0, 1'b0, 250);
        txn(2'd1, 2'b11, 1'b1, 1'b0, 1'b1, 255);
        txn(2'd1, 2'b11, 1'b1, 1'b0, 1'b1, 255);

        // Out-of-range account, then confirm the others are untouched.
        txn(2'd3, 2'b00, 1'b0, 1'b1, 1'b0, 0);
        txn(2'd3, 2'b11, 1'b0, 1'b1, 1'b0, 0);
        txn(2'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1);
        txn(2'd1, 2'b11, 1'b1, 1'b0, 1'b1, 255);

        // Debit equal to the balance empties the account.
        txn(2'd0, 2'b01, 1'b1, 1'b0, 1'b0, 50);
        txn(2'd0, 2'b10, 1'b1, 1'b0, 1'b0, 0);

        // Account 2 from its initial 100 up to exactly 255 (not saturated).
        for (int i = 0; i < 13; i++) begin
            txn(2'd2, t_op[i], 1'b1, 1'b0, 1'b0, t_bal[i]);
        end

        // Back-pressure: response held for 20 cycles with a request pending.
        rsp_ready = 1'b0;
        expect_rsp(1'b1, 1'b0, 1'b0, 49);
        send(2'd0, 2'b01);
        wait_rsp("hold latency");
        snap = {rsp_ok, rsp_err, rsp_sat, rsp_balance, rsp_bcd};
        expect_rsp(1'b1, 1'b0, 1'b0, 99);
        req_valid = 1'b1;
        req_acct  = 2'd0;
        req_op    = 2'b11;
        stable    = 1'b1;
        rdy_seen  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if ({rsp_ok, rsp_err, rsp_sat, rsp_balance, rsp_bcd} != snap || !rsp_valid) begin
                stable = 1'b0;
            end
            if (req_ready) begin
                rdy_seen = 1'b1;
            end
        end
        check("hold rsp stable", 32'(stable), 32'd1);
        check("hold req_ready low", 32'(rdy_seen), 32'd0);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        check("req_ready before handshake", 32'(req_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("req_ready after handshake", 32'(req_ready), 32'd1);
        check("rsp_valid after handshake", 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("pending req consumed", 32'(req_ready), 32'd0);
        begin
            int cyc;
            cyc = 1;
            while (!rsp_valid && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("pending latency", 32'(cyc - 1), 32'd10);
        end
        @(posedge clk);
        #1;

        // Reset during conversion of a debit on account 2 (255 -> 206 in flight).
        send(2'd2, 2'b00);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset rsp_valid",   32'(rsp_valid),   32'd0);
        check("midreset rsp_ok",      32'(rsp_ok),      32'd0);
        check("midreset rsp_balance", 32'(rsp_balance), 32'd0);
        check("midreset rsp_bcd",     32'(rsp_bcd),     32'd0);
        check("midreset req_ready",   32'(req_ready),   32'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        txn(2'd2, 2'b00, 1'b1, 1'b0, 1'b0, 51);
        txn(2'd0, 2'b00, 1'b1, 1'b0, 1'b0, 51);

        repeat (3) @(posedge clk);
        check("scoreboard drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
